decode_stage_ctrl: RTL and testbench
====================================

Name: decode_stage_ctrl

Overview:
Registered decode stage for the MIPS-32 pipeline. It replaces the flat combinational control decode with a valid/ready pipeline slot that adds byte/half/word load-store control. It also adds a multiply/divide (HI/LO) scoreboard that stalls HI/LO-dependent instructions until the multi-cycle MDU result is ready. It sits between the IF/ID register and the execute stage.

Parameters:
MUL_LAT, 4, cycles the MDU stays busy after an accepted MULT/MULTU
DIV_LAT, 33, cycles the MDU stays busy after an accepted DIV/DIVU
CNT_W, 6, scoreboard counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  instruction word present
in_ready  out  1  stage accepts the instruction this cycle
in_instr  in  32  instruction word
in_pc  in  32  PC of in_instr
flush  in  1  kill stage contents (branch/jump redirect)
out_valid  out  1  decoded entry valid
out_ready  in  1  execute stage accepts the entry
out_ctrl  out  15  registered control word
out_instr  out  32  registered instruction word
out_pc  out  32  registered PC
mdu_busy  out  1  scoreboard counter != 0

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- out_ctrl bit map:
  - [14:13] memsize (00 byte, 01 half, 10 word); [12] memsext
  - [11] memtoreg; [10] memen; [9] memwrite; [8] branch; [7] alusrc; [6] regdst; [5] regwrite; [4] hilowrite
  - [3] jump; [2] jal; [1] jr; [0] bal
- Decode (standard MIPS32 encodings):
  - ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI: alusrc, regwrite.
  - LB: size 00, sext. LBU: size 00. LH: size 01, sext. LHU: size 01. LW: size 10, sext. All loads also set memtoreg, memen, alusrc, regwrite.
  - SB/SH/SW: size 00/01/10; memen, memwrite, alusrc.
  - J: jump. JAL: jump, jal, regwrite.
  - BEQ/BNE/BLEZ/BGTZ, and REGIMM rt=BLTZ/BGEZ: branch.
  - REGIMM rt=BLTZAL/BGEZAL: branch, regwrite, bal.
  - SPECIAL ALU/shift/MFHI/MFLO: regdst, regwrite.
  - SPECIAL MTHI/MTLO/MULT/MULTU/DIV/DIVU: hilowrite.
  - SPECIAL JR: jump, jr. JALR: jump, jr, jal, regdst, regwrite.
  - Unrecognised op/funct/rt, and instr==0 (NOP): all-zero control word.
- HI/LO hazard:
  - An instruction is "hilo-class" if it is MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV or DIVU.
  - hazard = in_valid & hilo-class(in_instr) & (cnt != 0).
- in_ready = (!out_valid | out_ready) & !hazard & !flush. It is combinational.
- Accept (in_valid & in_ready): next cycle out_valid=1; out_ctrl/out_instr/out_pc load the decoded values. Latency is 1 cycle.
- Drain (out_valid & out_ready with no accept): next cycle out_valid=0. Payload holds its value; it is don't-care while invalid.
- Stall (out_valid & !out_ready): all outputs hold stable.
- flush=1: next cycle out_valid=0 and there is no accept that cycle. Flush has priority over accept and drain.
- Scoreboard FSM:
  - IDLE (cnt==0): an accepted MULT/MULTU loads cnt=MUL_LAT; an accepted DIV/DIVU loads cnt=DIV_LAT; next state is BUSY.
  - BUSY: cnt decrements by 1 per cycle. When cnt reaches 0 the state returns to IDLE.
  - No accept of an MDU op is possible while BUSY, because MDU ops are hilo-class.
  - flush does not clear cnt; this is conservative, since an MDU op is treated as issued once accepted.
- Reset: out_valid=0, out_ctrl=0, out_instr=0, out_pc=0, cnt=0 (IDLE), mdu_busy=0. Reset overrides flush and accept in the same cycle.
- No combinational path from in_instr to any out_* port. in_ready depends on in_instr through hazard only.

Optional Feature:
Macro DECODE_RI_TRAP_EN.
- Defined: adds output port out_ri (1 bit, registered alongside out_ctrl, reset 0). out_ri=1 for any unrecognised encoding; out_ctrl for that entry is still all-zero. instr==0 is recognised (out_ri=0).
- Undefined: the port is absent and unrecognised encodings silently decode to all-zero control.

Test Plan:
- rst for 2 cycles, then in_instr=0x8C820004 (LW) with in_valid=1 and out_ready=1 -> next cycle out_valid=1, out_ctrl=0x5CA0, out_pc=in_pc.
- SB 0xA0A20000 -> out_ctrl=0x0680. BGEZAL 0x04910003 -> out_ctrl=0x0121. instr 0x00000000 -> out_ctrl=0x0000.
- MULT 0x00850018 accepted, then MFLO 0x00001012 presented -> in_ready=0 and mdu_busy=1 for exactly 4 cycles; MFLO accepted in the first cycle with cnt=0 -> out_ctrl=0x0060.
- DIV 0x0085001A, then ADDU 0x00851021 -> ADDU is accepted the next cycle with no stall; a following MFHI stalls until 33 cycles after the DIV accept.
- out_ready=0 for 5 cycles with an entry held -> out_* stable and in_ready=0; assert flush -> out_valid=0 the next cycle.
- With DECODE_RI_TRAP_EN defined, in_instr=0xFC000000 -> out_ri=1 and out_ctrl=0x0000.

Source files
------------

// File: rtl/decode_stage_ctrl.sv
// ---------------------------------------------------------------------------
// decode_stage_ctrl
//
// Registered MIPS-32 decode stage. It sits between the IF/ID register and the
// execute stage as a single valid/ready pipeline slot. The stage decodes
// load/store byte/half/word control. It also keeps a HI/LO scoreboard that
// holds back HI/LO-dependent instructions while the multi-cycle
// multiply/divide unit is still busy.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is combinational)
//   in_instr, in_pc     instruction word and its PC
//   flush               kill the slot contents (branch/jump redirect)
//   out_valid/out_ready downstream handshake
//   out_ctrl[14:0]      registered control word:
//                       [14:13] memsize  [12] memsext  [11] memtoreg
//                       [10] memen  [9] memwrite  [8] branch  [7] alusrc
//                       [6] regdst  [5] regwrite  [4] hilowrite
//                       [3] jump  [2] jal  [1] jr  [0] bal
//   out_instr, out_pc   registered instruction word and PC
//   out_ri              (DECODE_RI_TRAP_EN only) unrecognised-encoding flag
//   mdu_busy            scoreboard counter is non-zero
//
// Optional feature macro: DECODE_RI_TRAP_EN adds the out_ri output.
// ---------------------------------------------------------------------------
module decode_stage_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] out_ctrl,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
`ifdef DECODE_RI_TRAP_EN
  output logic        out_ri,
`endif
  output logic        mdu_busy
);

  typedef enum logic {SB_IDLE, SB_BUSY} sb_state_e;

  localparam logic [14:0] C_SZ_HALF  = 15'h2000;
  localparam logic [14:0] C_SZ_WORD  = 15'h4000;
  localparam logic [14:0] C_SEXT     = 15'h1000;
  localparam logic [14:0] C_MEMTOREG = 15'h0800;
  localparam logic [14:0] C_MEMEN    = 15'h0400;
  localparam logic [14:0] C_MEMWRITE = 15'h0200;
  localparam logic [14:0] C_BRANCH   = 15'h0100;
  localparam logic [14:0] C_ALUSRC   = 15'h0080;
  localparam logic [14:0] C_REGDST   = 15'h0040;
  localparam logic [14:0] C_REGWRITE = 15'h0020;
  localparam logic [14:0] C_HILOWR   = 15'h0010;
  localparam logic [14:0] C_JUMP     = 15'h0008;
  localparam logic [14:0] C_JAL      = 15'h0004;
  localparam logic [14:0] C_JR       = 15'h0002;
  localparam logic [14:0] C_BAL      = 15'h0001;

  localparam logic [14:0] C_LOAD  = C_MEMTOREG | C_MEMEN | C_ALUSRC | C_REGWRITE;
  localparam logic [14:0] C_STORE = C_MEMEN | C_MEMWRITE | C_ALUSRC;

  logic            out_valid_q, out_valid_d;
  logic [14:0]     out_ctrl_q, out_ctrl_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic [31:0]     out_pc_q, out_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sb_state_e       state_q, state_d;

  logic [14:0] ctrl_dec;
  logic        hilo_class, is_mul, is_div;
  logic        hazard, accept;

  // Instruction decode. The all-zero word is SLL $0,$0,0 but is treated as a
  // NOP with an empty control word.
  always_comb begin
    ctrl_dec   = '0;
    hilo_class = 1'b0;
    is_mul     = 1'b0;
    is_div     = 1'b0;
    if (in_instr != 32'h0) begin
      unique case (in_instr[31:26])
        6'h00: begin
          unique case (in_instr[5:0])
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
            6'h26, 6'h27, 6'h2a, 6'h2b: ctrl_dec = C_REGDST | C_REGWRITE;
            6'h10, 6'h12: begin
              ctrl_dec   = C_REGDST | C_REGWRITE;
              hilo_class = 1'b1;
            end
            6'h11, 6'h13: begin
              ctrl_dec   = C_HILOWR;
              hilo_class = 1'b1;
            end
            6'h18, 6'h19: begin
              ctrl_dec   = C_HILOWR;
              hilo_class = 1'b1;
              is_mul     = 1'b1;
            end
            6'h1a, 6'h1b: begin
              ctrl_dec   = C_HILOWR;
              hilo_class = 1'b1;
              is_div     = 1'b1;
            end
            6'h08:   ctrl_dec = C_JUMP | C_JR;
            6'h09:   ctrl_dec = C_JUMP | C_JR | C_JAL | C_REGDST | C_REGWRITE;
            default: ctrl_dec = '0;
          endcase
        end
        6'h01: begin
          unique case (in_instr[20:16])
            5'h00, 5'h01: ctrl_dec = C_BRANCH;
            5'h10, 5'h11: ctrl_dec = C_BRANCH | C_REGWRITE | C_BAL;
            default:      ctrl_dec = '0;
          endcase
        end
        6'h02: ctrl_dec = C_JUMP;
        6'h03: ctrl_dec = C_JUMP | C_JAL | C_REGWRITE;
        6'h04, 6'h05, 6'h06, 6'h07: ctrl_dec = C_BRANCH;
        6'h08, 6'h09, 6'h0a, 6'h0b,
        6'h0c, 6'h0d, 6'h0e, 6'h0f: ctrl_dec = C_ALUSRC | C_REGWRITE;
        6'h20: ctrl_dec = C_LOAD | C_SEXT;
        6'h24: ctrl_dec = C_LOAD;
        6'h21: ctrl_dec = C_LOAD | C_SZ_HALF | C_SEXT;
        6'h25: ctrl_dec = C_LOAD | C_SZ_HALF;
        6'h23: ctrl_dec = C_LOAD | C_SZ_WORD | C_SEXT;
        6'h28: ctrl_dec = C_STORE;
        6'h29: ctrl_dec = C_STORE | C_SZ_HALF;
        6'h2b: ctrl_dec = C_STORE | C_SZ_WORD;
        default: ctrl_dec = '0;
      endcase
    end
  end

  // HI/LO-class instructions wait while the MDU result is outstanding.
  // Flush blocks acceptance so a redirect never lets a stale instruction in.
  assign hazard   = in_valid & hilo_class & (cnt_q != '0);
  assign in_ready = (!out_valid_q | out_ready) & !hazard & !flush;
  assign accept   = in_valid & in_ready;

  // Slot next-state: flush beats accept beats drain. The payload only loads
  // on accept, so it holds through stalls and drains.
  always_comb begin
    out_valid_d = out_valid_q;
    out_ctrl_d  = out_ctrl_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_ctrl_d  = ctrl_dec;
      out_instr_d = in_instr;
      out_pc_d    = in_pc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Scoreboard: load the MDU latency on an accepted multiply/divide, then
  // count down. Flush deliberately leaves the count alone, because the MDU
  // op was already issued.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SB_IDLE: begin
        if (accept && is_mul) begin
          cnt_d   = CNT_W'(MUL_LAT);
          state_d = SB_BUSY;
        end else if (accept && is_div) begin
          cnt_d   = CNT_W'(DIV_LAT);
          state_d = SB_BUSY;
        end
      end
      SB_BUSY: begin
        cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        if (cnt_q <= CNT_W'(1)) state_d = SB_IDLE;
      end
      default: state_d = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ctrl_q  <= '0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      cnt_q       <= '0;
      state_q     <= SB_IDLE;
    end else begin
      out_valid_q <= out_valid_d;
      out_ctrl_q  <= out_ctrl_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
    end
  end

`ifdef DECODE_RI_TRAP_EN
  // Every recognised non-NOP encoding sets at least one control bit, so an
  // empty control word on a non-zero instruction marks it as unrecognised.
  logic out_ri_q, out_ri_d;

  always_comb begin
    out_ri_d = out_ri_q;
    if (!flush && accept) out_ri_d = (ctrl_dec == '0) && (in_instr != 32'h0);
  end

  always_ff @(posedge clk) begin
    if (rst) out_ri_q <= 1'b0;
    else     out_ri_q <= out_ri_d;
  end

  assign out_ri = out_ri_q;
`endif

  assign out_valid = out_valid_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign mdu_busy  = (cnt_q != '0);

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_decode_stage_ctrl
//
// Testbench for decode_stage_ctrl. The stimulus side pushes the expected
// {ri, ctrl, instr, pc} entry when an instruction is accepted. A monitor pops
// and compares that entry whenever the DUT hands an entry downstream.
// Inputs change 1 time unit after the rising edge; the DUT is sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_decode_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_ctrl;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef DECODE_RI_TRAP_EN
  logic        out_ri;
`endif
  logic        mdu_busy;

  int          n_checks;
  int          n_fail;
  logic [79:0] exp_q [$];
  logic [79:0] mon_entry;
  int          st;

  localparam int NVEC = 12;
  logic [31:0] vec_instr [NVEC] = '{
    32'hA0A20000, 32'h04910003, 32'h00000000, 32'h90820000,
    32'h84820000, 32'hA4820000, 32'h0C000010, 32'h03E00008,
    32'h24420001, 32'h10850002, 32'h0080F809, 32'h08000040
  };
  logic [14:0] vec_ctrl [NVEC] = '{
    15'h0680, 15'h0121, 15'h0000, 15'h0CA0,
    15'h3CA0, 15'h2680, 15'h002C, 15'h000A,
    15'h00A0, 15'h0100, 15'h006E, 15'h0008
  };

  decode_stage_ctrl #(
    .MUL_LAT(4),
    .DIV_LAT(33),
    .CNT_W  (6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .in_pc    (in_pc),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_instr(out_instr),
    .out_pc   (out_pc),
`ifdef DECODE_RI_TRAP_EN
    .out_ri   (out_ri),
`endif
    .mdu_busy (mdu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Present one instruction and wait until it is accepted. Call at
  // posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [14:0] ctrl, input logic ri,
                               output int stalls);
    bit timed_out;
    stalls    = 0;
    timed_out = 1'b0;
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pc     = pc;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      if (stalls > 200) begin
        timed_out = 1'b1;
        break;
      end
    end
    if (timed_out) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: got no accept, expected accept of 0x%08h", instr);
      @(posedge clk);
    end else begin
      @(posedge clk);
      exp_q.push_back({ri, ctrl, instr, pc});
    end
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every entry handed downstream must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_output: got entry pc 0x%08h, expected none", out_pc);
      end else begin
        mon_entry = exp_q.pop_front();
        checkOutput("out_ctrl", 32'(out_ctrl), 32'(mon_entry[78:64]));
        checkOutput("out_instr", out_instr, mon_entry[63:32]);
        checkOutput("out_pc", out_pc, mon_entry[31:0]);
`ifdef DECODE_RI_TRAP_EN
        checkOutput("out_ri", 32'(out_ri), 32'(mon_entry[79]));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_pc     = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_ctrl", 32'(out_ctrl), 32'd0);
    checkOutput("rst_out_instr", out_instr, 32'd0);
    checkOutput("rst_out_pc", out_pc, 32'd0);
    checkOutput("rst_mdu_busy", 32'(mdu_busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // LW with one-cycle latency
    applyStimulus(32'h8C820004, 32'h00000100, 15'h5CA0, 1'b0, st);
    checkOutput("lw_stalls", 32'(st), 32'd0);
    checkOutput("lw_latency_valid", 32'(out_valid), 32'd1);
    checkOutput("lw_latency_pc", out_pc, 32'h00000100);

    // Back-to-back decode table
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vec_instr[i], 32'h00000200 + 32'(i * 4), vec_ctrl[i], 1'b0, st);
      checkOutput("table_stalls", 32'(st), 32'd0);
    end

    // MULT then MFLO: 4 stall cycles
    applyStimulus(32'h00850018, 32'h00000300, 15'h0010, 1'b0, st);
    checkOutput("mult_busy", 32'(mdu_busy), 32'd1);
    applyStimulus(32'h00001012, 32'h00000304, 15'h0060, 1'b0, st);
    checkOutput("mflo_stalls", 32'(st), 32'd4);
    checkOutput("mflo_mdu_idle", 32'(mdu_busy), 32'd0);

    // DIV, ADDU passes freely, MFHI waits for the divide
    applyStimulus(32'h0085001A, 32'h00000310, 15'h0010, 1'b0, st);
    applyStimulus(32'h00851021, 32'h00000314, 15'h0060, 1'b0, st);
    checkOutput("addu_stalls", 32'(st), 32'd0);
    checkOutput("div_busy", 32'(mdu_busy), 32'd1);
    applyStimulus(32'h00001010, 32'h00000318, 15'h0060, 1'b0, st);
    checkOutput("mfhi_stalls", 32'(st), 32'd32);

    // Downstream stall holds the entry, then flush kills it
    applyStimulus(32'h34420005, 32'h00000400, 15'h00A0, 1'b0, st);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h38420001;
    in_pc     = 32'h00000404;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_ctrl", 32'(out_ctrl), 32'h00A0);
      checkOutput("hold_instr", out_instr, 32'h34420005);
      checkOutput("hold_pc", out_pc, 32'h00000400);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_kill_valid", 32'(out_valid), 32'd0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    out_ready = 1'b1;

    // Flush beats an otherwise-possible accept
    in_valid = 1'b1;
    in_instr = 32'h38420001;
    in_pc    = 32'h00000408;
    flush    = 1'b1;
    @(negedge clk);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_no_accept", 32'(out_valid), 32'd0);
    applyStimulus(32'h38420001, 32'h0000040C, 15'h00A0, 1'b0, st);
    checkOutput("xori_stalls", 32'(st), 32'd0);

    // Unrecognised encoding
    applyStimulus(32'hFC000000, 32'h00000500, 15'h0000, 1'b1, st);

    // Mid-run reset overrides accept and clears the scoreboard
    applyStimulus(32'h00850019, 32'h00000600, 15'h0010, 1'b0, st);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h24420001;
    in_pc    = 32'h00000604;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    checkOutput("rst2_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst2_out_ctrl", 32'(out_ctrl), 32'd0);
    checkOutput("rst2_out_instr", out_instr, 32'd0);
    checkOutput("rst2_out_pc", out_pc, 32'd0);
    checkOutput("rst2_mdu_busy", 32'(mdu_busy), 32'd0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    applyStimulus(32'h00001012, 32'h00000700, 15'h0060, 1'b0, st);
    checkOutput("post_rst_mflo_stalls", 32'(st), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
